// File: rtl/data_memory_sized.sv
// Purpose: byte-addressed little-endian data memory with sized loads/stores, error flags and an init sweep.
// Latency: loads and flags are combinational; stores land on the rising edge; the sweep takes DEPTH_BYTES/4 cycles.
// Backpressure: Busy high during the sweep; stores are dropped and loads return zero until it falls.
module data_memory_sized #(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DEPTH_BYTES = 64,
  parameter logic [31:0] INIT_VALUE  = 32'd1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           WriteData,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [1:0]            MemSize,
  input  logic                  MemSigned,
  input  logic                  Startin,
  output logic [31:0]           ReadData,
  output logic                  Busy,
  output logic                  Misaligned,
  output logic                  OutOfRange,
  output logic                  ErrorSticky
);

  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  // Byte index width: word counter plus the two byte-lane bits.
  localparam int IW    = CW + 2;
  localparam logic [CW-1:0]       LAST_WORD = CW'(WORDS - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH_BYTES);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic                err_q;
  logic [7:0]          mem [DEPTH_BYTES];

  logic                access;
  logic                mis_raw;
  logic                oor_raw;
  logic                error;
  logic                start_ok;
  logic [2:0]          size_n;
  logic [ADDR_WIDTH:0] end_addr;
  logic [IW-1:0]       base_idx;
  logic [7:0]          rb [4];

  assign Busy        = (state_q == SWEEP);
  assign ErrorSticky = err_q;
  assign start_ok    = Startin && !Busy;
  assign access      = (MemRead || MemWrite) && !Busy;
  assign base_idx    = Address[IW-1:0];

  // Access size in bytes; the reserved encoding is caught by the alignment check.
  always_comb begin
    size_n = 3'd4;
    case (MemSize)
      2'b00:   size_n = 3'd1;
      2'b01:   size_n = 3'd2;
      default: size_n = 3'd4;
    endcase
  end

  // Alignment and range checks; the extra address bit keeps the top of the space from wrapping to zero.
  always_comb begin
    mis_raw  = (MemSize == 2'b11) ||
               ((MemSize == 2'b01) && Address[0]) ||
               ((MemSize == 2'b10) && (Address[1:0] != 2'b00));
    end_addr = {1'b0, Address} + (ADDR_WIDTH + 1)'(size_n);
    oor_raw  = (end_addr > DEPTH_EXT);
  end

  assign Misaligned = access && mis_raw;
  assign OutOfRange = access && oor_raw;
  assign error      = Misaligned || OutOfRange;

  // Fetch the four bytes starting at Address; lanes past the array end read as zero.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rb[k] = 8'h00;
      if (int'(base_idx + IW'(k)) < DEPTH_BYTES)
        rb[k] = mem[base_idx + IW'(k)];
    end
  end

  // Assemble the load result with sign or zero extension; zero whenever the load is not valid.
  always_comb begin
    ReadData = 32'h0;
    if (MemRead && !Busy && !error) begin
      case (MemSize)
        2'b00:   ReadData = MemSigned ? {{24{rb[0][7]}}, rb[0]} : {24'h0, rb[0]};
        2'b01:   ReadData = MemSigned ? {{16{rb[1][7]}}, rb[1], rb[0]} : {16'h0, rb[1], rb[0]};
        default: ReadData = {rb[3], rb[2], rb[1], rb[0]};
      endcase
    end
  end

  // Memory array: sweep writes one whole word per cycle, otherwise qualified stores write N bytes.
  always_ff @(posedge clk) begin
    if (Busy) begin
      for (int k = 0; k < 4; k++)
        mem[{cnt_q, 2'b00} + IW'(k)] <= INIT_VALUE[8*k +: 8];
    end else if (MemWrite && !Startin && !error) begin
      for (int k = 0; k < 4; k++)
        if (k < int'(size_n))
          mem[base_idx + IW'(k)] <= WriteData[8*k +: 8];
    end
  end

  // FSM next state: leave IDLE on Startin, return after the last word is written.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Startin) state_d = SWEEP;
      SWEEP:   if (cnt_q == LAST_WORD) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, sweep counter and sticky error; an accepted Startin clears the sticky flag over any new error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok)
        cnt_q <= '0;
      else if (Busy)
        cnt_q <= cnt_q + 1'b1;
      if (start_ok)
        err_q <= 1'b0;
      else if (error)
        err_q <= 1'b1;
    end
  end

endmodule
